qsys_irq_ctrl: RTL

QSYS_IRQ_CTRL -- requirements
Module: qsys_irq_ctrl

---
 rtl/qsys_irq_ctrl_pkg.sv | 38 +++
 rtl/qsys_irq_ctrl_if.sv | 20 ++
 rtl/qsys_irq_sync.sv | 28 ++
 rtl/qsys_irq_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/qsys_irq_ctrl_pkg.sv
// Shared definitions for the qsys_irq_ctrl interrupt controller.
//   - register address map (3-bit Avalon-MM word address)
//   - maximum number of interrupt lines (register width)
//   - ACTIVE_ID field positions and a helper that builds the ACTIVE_ID word
package qsys_irq_ctrl_pkg;

  localparam int NUM_IRQ_MAX = 16;
  localparam int ADDR_W      = 3;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_STATUS    = 3'd0,
    ADDR_PENDING   = 3'd1,
    ADDR_ENABLE    = 3'd2,
    ADDR_EDGE_SEL  = 3'd3,
    ADDR_ACTIVE_ID = 3'd4,
    ADDR_ACK       = 3'd5
  } reg_addr_e;

  localparam int ACTIVE_ID_VALID_BIT = 15;
  localparam int ACTIVE_ID_LSB       = 0;
  localparam int ACTIVE_ID_W         = 4;

  // Lowest-numbered set bit wins. Scanning from the top down lets each lower
  // hit overwrite the previous one, so the final value is the lowest index.
  function automatic logic [NUM_IRQ_MAX-1:0] active_id_word(input logic [NUM_IRQ_MAX-1:0] vec);
    logic [NUM_IRQ_MAX-1:0] word;
    word = '0;
    for (int i = NUM_IRQ_MAX - 1; i >= 0; i--) begin
      if (vec[i]) begin
        word = '0;
        word[ACTIVE_ID_VALID_BIT] = 1'b1;
        word[ACTIVE_ID_LSB +: ACTIVE_ID_W] = ACTIVE_ID_W'(i);
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/qsys_irq_ctrl_if.sv
// Avalon-MM slave bus for qsys_irq_ctrl.
//   address    : word address (see reg_addr_e)
//   chipselect : access strobe
//   write_n    : active-low write qualifier
//   writedata  : write data
//   readdata   : registered read data, one cycle after address
// Modports: master (CPU/bench side), slave (controller side).
interface qsys_irq_ctrl_if;
  import qsys_irq_ctrl_pkg::*;

  logic [ADDR_W-1:0]      address;
  logic                   chipselect;
  logic                   write_n;
  logic [NUM_IRQ_MAX-1:0] writedata;
  logic [NUM_IRQ_MAX-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/qsys_irq_sync.sv
// Single-bit multi-flop synchronizer for one raw interrupt line.
//   clk, reset_n : clock, asynchronous active-low reset
//   d            : raw (possibly asynchronous) input
//   q            : synchronized output, SYNC_STAGES clocks behind d
module qsys_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/qsys_irq_ctrl.sv
// Interrupt controller with Avalon-MM register access.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   irq_in       : raw interrupt sources (NUM_IRQ wide, possibly asynchronous)
//   bus          : Avalon-MM slave (qsys_irq_ctrl_if.slave)
//   irq          : registered aggregated interrupt to the CPU
// Build option: define QSYS_IRQ_EDGE_EN to build edge-capture lines, EDGE_SEL
// and ACK. Without it every line is level-sensitive and EDGE_SEL/ACK read 0.
module qsys_irq_ctrl
  import qsys_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  qsys_irq_ctrl_if.slave     bus,
  output logic               irq
);

  localparam logic [NUM_IRQ_MAX-1:0] IRQ_MASK = NUM_IRQ_MAX'((32'd1 << NUM_IRQ) - 32'd1);

  logic [NUM_IRQ-1:0]     sync_irq;
  logic [NUM_IRQ_MAX-1:0] sync_ext;
  logic [NUM_IRQ_MAX-1:0] pending;
  logic [NUM_IRQ_MAX-1:0] active;
  logic [NUM_IRQ_MAX-1:0] edge_sel;
  logic [NUM_IRQ_MAX-1:0] edge_pend;
  logic                   wr;
  logic                   wr_enable;

  logic [NUM_IRQ_MAX-1:0] enable_q,   enable_d;
  logic [NUM_IRQ_MAX-1:0] readdata_q, readdata_d;
  logic                   irq_q,      irq_d;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    qsys_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (irq_in[i]),
      .q       (sync_irq[i])
    );
  end

  // Internal vectors are full register width; bits above NUM_IRQ stay 0.
  assign sync_ext  = NUM_IRQ_MAX'(sync_irq);
  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_enable = wr && (bus.address == ADDR_ENABLE);

`ifdef QSYS_IRQ_EDGE_EN
  logic                   wr_pending;
  logic                   wr_edge_sel;
  logic                   wr_ack;
  logic [NUM_IRQ_MAX-1:0] rise;
  logic [NUM_IRQ_MAX-1:0] clr;
  logic [NUM_IRQ_MAX-1:0] sel_change;
  logic [NUM_IRQ_MAX-1:0] edge_sel_q,  edge_sel_d;
  logic [NUM_IRQ_MAX-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ_MAX-1:0] sync_dly_q,  sync_dly_d;

  assign wr_pending  = wr && (bus.address == ADDR_PENDING);
  assign wr_edge_sel = wr && (bus.address == ADDR_EDGE_SEL);
  assign wr_ack      = wr && (bus.address == ADDR_ACK);

  // Edge capture: a rise on an edge line sets its pending flop and beats a
  // same-cycle W1C/ACK. Changing a line's EDGE_SEL discards its pending edge.
  // Only lines already configured as edge can capture, so an input that is
  // high when software first selects edge mode does not look like an event.
  always_comb begin
    sync_dly_d = sync_ext;
    rise       = sync_ext & ~sync_dly_q & edge_sel_q;
    edge_sel_d = edge_sel_q;
    if (wr_edge_sel) edge_sel_d = bus.writedata & IRQ_MASK;
    sel_change = edge_sel_d ^ edge_sel_q;
    clr        = '0;
    if (wr_pending) clr = clr | bus.writedata;
    if (wr_ack)     clr = clr | (NUM_IRQ_MAX'(1) << bus.writedata[ACTIVE_ID_W-1:0]);
    edge_pend_d = ((edge_pend_q & ~clr) | rise) & ~sel_change & IRQ_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_q  <= '0;
      edge_pend_q <= '0;
      sync_dly_q  <= '0;
    end else begin
      edge_sel_q  <= edge_sel_d;
      edge_pend_q <= edge_pend_d;
      sync_dly_q  <= sync_dly_d;
    end
  end

  assign edge_sel  = edge_sel_q;
  assign edge_pend = edge_pend_q;
`else
  assign edge_sel  = '0;
  assign edge_pend = '0;
`endif

  // Level lines mirror the synchronized input; edge lines use the capture flop.
  // readdata is refreshed every clock from the current address.
  always_comb begin
    enable_d = enable_q;
    if (wr_enable) enable_d = bus.writedata & IRQ_MASK;
    pending = (~edge_sel & sync_ext) | (edge_sel & edge_pend);
    active  = pending & enable_q;
    irq_d   = |active;
    case (bus.address)
      ADDR_STATUS:    readdata_d = sync_ext;
      ADDR_PENDING:   readdata_d = pending;
      ADDR_ENABLE:    readdata_d = enable_q;
      ADDR_EDGE_SEL:  readdata_d = edge_sel;
      ADDR_ACTIVE_ID: readdata_d = active_id_word(active);
      default:        readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
